write_back: RTL and testbench

WRITE_BACK -- requirements
Module: write_back

---
 rtl/write_back_pkg.sv | 11 +
 rtl/wb_result_mux.sv | 13 +
 rtl/write_back.sv | 68 ++++++
 tb/tb_write_back.sv | 119 +++++++++++
 4 files changed

// File: rtl/write_back_pkg.sv
// Shared widths, zero-register index and datapath typedefs for the write-back stage.
package write_back_pkg;

    localparam int DATA_W   = 64;
    localparam int REG_AW   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_AW-1:0] regaddr_t;

endpackage : write_back_pkg

// File: rtl/wb_result_mux.sv
// Write-back data select: y = a when sel is 1 (loaded data), otherwise b (ALU result).
module wb_result_mux #(
    parameter int W = 64
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? a : b;

endmodule : wb_result_mux

// File: rtl/write_back.sv
// Single registered write-back stage with stall hold and synchronous reset.
// Optional macro WB_XZR_SQUASH_EN squashes writes (and data) targeting the zero register.
module write_back #(
    parameter int DATA_W   = write_back_pkg::DATA_W,
    parameter int REG_AW   = write_back_pkg::REG_AW,
    parameter int ZERO_REG = write_back_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RdI,
    input  logic [DATA_W-1:0] loadedDataI,
    input  logic [DATA_W-1:0] ResultsI,
    input  logic              MemToRegI,
    input  logic              RegWriteI,
    input  logic              stall,
    output logic [DATA_W-1:0] Data2Write,
    output logic [REG_AW-1:0] Reg2Write,
    output logic              oldRegWrite
);

    import write_back_pkg::*;

    logic [DATA_W-1:0] w_mux_y;
    logic [DATA_W-1:0] w_data_next;
    logic              w_wen_next;

    logic [DATA_W-1:0] r_data;
    logic [REG_AW-1:0] r_rd;
    logic              r_wen;

    wb_result_mux #(
        .W(DATA_W)
    ) u_result_mux (
        .sel(MemToRegI),
        .a  (loadedDataI),
        .b  (ResultsI),
        .y  (w_mux_y)
    );

`ifdef WB_XZR_SQUASH_EN
    logic w_is_xzr;

    // The destination index still passes through; only the enable and data are killed.
    assign w_is_xzr    = (RdI == REG_AW'(ZERO_REG));
    assign w_data_next = w_is_xzr ? '0 : w_mux_y;
    assign w_wen_next  = RegWriteI & ~w_is_xzr;
`else
    assign w_data_next = w_mux_y;
    assign w_wen_next  = RegWriteI;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_rd   <= '0;
            r_wen  <= 1'b0;
        end else if (!stall) begin
            r_data <= w_data_next;
            r_rd   <= RdI;
            r_wen  <= w_wen_next;
        end
    end

    assign Data2Write  = r_data;
    assign Reg2Write   = r_rd;
    assign oldRegWrite = r_wen;

endmodule : write_back

// File: tb/tb_write_back.sv
// Directed, table-driven bench for write_back; expectations follow WB_XZR_SQUASH_EN.
module tb_write_back;

    logic        clk;
    logic        reset;
    logic [4:0]  RdI;
    logic [63:0] loadedDataI;
    logic [63:0] ResultsI;
    logic        MemToRegI;
    logic        RegWriteI;
    logic        stall;
    logic [63:0] Data2Write;
    logic [4:0]  Reg2Write;
    logic        oldRegWrite;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] ld;
        logic [63:0] res;
        logic        m2r;
        logic        we;
        logic        stl;
        logic [63:0] exp_data;
        logic [4:0]  exp_rd;
        logic        exp_we;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    write_back dut (
        .clk        (clk),
        .reset      (reset),
        .RdI        (RdI),
        .loadedDataI(loadedDataI),
        .ResultsI   (ResultsI),
        .MemToRegI  (MemToRegI),
        .RegWriteI  (RegWriteI),
        .stall      (stall),
        .Data2Write (Data2Write),
        .Reg2Write  (Reg2Write),
        .oldRegWrite(oldRegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] ed, input logic [4:0] er, input logic ew);
        check({tag, ".data"}, Data2Write, ed);
        check({tag, ".rd"}, 64'(Reg2Write), 64'(er));
        check({tag, ".we"}, 64'(oldRegWrite), 64'(ew));
    endtask

    task automatic drive(input logic [4:0] rd, input logic [63:0] ld, input logic [63:0] res,
                         input logic m2r, input logic we, input logic stl, input logic rst);
        RdI = rd; loadedDataI = ld; ResultsI = res;
        MemToRegI = m2r; RegWriteI = we; stall = stl; reset = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{5'd5, 64'hDEAD, 64'h2A, 1'b0, 1'b1, 1'b0, 64'h2A, 5'd5, 1'b1};
        vecs[1] = '{5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b1, 1'b1, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1'b1};
        vecs[2] = '{5'd7, 64'h1234, 64'h99, 1'b1, 1'b0, 1'b0, 64'h1234, 5'd7, 1'b0};
        vecs[3] = '{5'd3, 64'h0, 64'h7, 1'b0, 1'b1, 1'b0, 64'h7, 5'd3, 1'b1};
        vecs[4] = '{5'd4, 64'h0, 64'h8, 1'b0, 1'b1, 1'b1, 64'h7, 5'd3, 1'b1};
        vecs[5] = '{5'd4, 64'h0, 64'h8, 1'b0, 1'b1, 1'b1, 64'h7, 5'd3, 1'b1};
        vecs[6] = '{5'd4, 64'h0, 64'h8, 1'b0, 1'b1, 1'b1, 64'h7, 5'd3, 1'b1};
        vecs[7] = '{5'd4, 64'h0, 64'h8, 1'b0, 1'b1, 1'b0, 64'h8, 5'd4, 1'b1};
`ifdef WB_XZR_SQUASH_EN
        vecs[8] = '{5'd31, 64'h66, 64'h55, 1'b0, 1'b1, 1'b0, 64'h0, 5'd31, 1'b0};
`else
        vecs[8] = '{5'd31, 64'h66, 64'h55, 1'b0, 1'b1, 1'b0, 64'h55, 5'd31, 1'b1};
`endif
        vecs[9] = '{5'd0, 64'h1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 1'b1, 1'b0,
                    64'hA5A5_5A5A_0F0F_F0F0, 5'd0, 1'b1};

        // Reset held for two edges with random inputs
        drive(5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom), 1'b1, 1'($urandom), 1'b1);
        drive(5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom), 1'b1, 1'($urandom), 1'b1);
        check_all("reset", 64'h0, 5'd0, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rd, vecs[i].ld, vecs[i].res, vecs[i].m2r, vecs[i].we, vecs[i].stl, 1'b0);
            check_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_rd, vecs[i].exp_we);
        end

        // Reset arriving while stalled must still clear the stage
        drive(5'd12, 64'hBEEF, 64'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        check_all("preload", 64'hBEEF, 5'd12, 1'b1);
        drive(5'd13, 64'h1111, 64'h2222, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all("stall_hold", 64'hBEEF, 5'd12, 1'b1);
        drive(5'd13, 64'h1111, 64'h2222, 1'b0, 1'b1, 1'b1, 1'b1);
        check_all("rst_in_stall", 64'h0, 5'd0, 1'b0);
        drive(5'd14, 64'h3333, 64'h4444, 1'b0, 1'b1, 1'b1, 1'b0);
        check_all("post_rst_stall", 64'h0, 5'd0, 1'b0);
        drive(5'd14, 64'h3333, 64'h4444, 1'b0, 1'b1, 1'b0, 1'b0);
        check_all("resume", 64'h4444, 5'd14, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_write_back
